// File: rtl/uart_tx_if.sv
// Word-side valid/ready handshake and serial-line status of uart_tx.
// master = upstream word source, slave = the transmitter.
interface uart_tx_if #(
    parameter int PACK_SIZE = 8
);
    logic                 tx_byte_valid;
    logic [PACK_SIZE-1:0] tx_byte_data;
    logic                 tx_ready;
    logic                 tx_bit;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        output tx_byte_valid, tx_byte_data,
        input  tx_ready, tx_bit, tx_active, tx_done
    );

    modport slave (
        input  tx_byte_valid, tx_byte_data,
        output tx_ready, tx_bit, tx_active, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PACK_SIZE data bits LSB first, STOP_BITS stop bits,
// idle high; valid/ready word input that accepts back-to-back frames without a gap.
module uart_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter int PACK_SIZE   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int CNT_W  = $clog2(CLK_PER_BIT);
    localparam int IDX_W  = $clog2(PACK_SIZE + 1);
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PACK_SIZE - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [CNT_W-1:0]     w_clk_cnt_next;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_bit_idx_next;
    logic [STOP_W-1:0]    r_stop_cnt;
    logic [STOP_W-1:0]    w_stop_cnt_next;
    logic [PACK_SIZE-1:0] r_shift;
    logic [PACK_SIZE-1:0] w_shift_next;
    logic                 r_tx_bit;
    logic                 w_tx_bit_next;
    logic                 r_tx_active;

    logic w_bit_end;
    logic w_last_stop;
    logic w_ready;
    logic w_accept;

    assign w_bit_end   = (r_clk_cnt == CNT_LAST);
    assign w_last_stop = (r_state == STOP) && w_bit_end && (r_stop_cnt == STOP_LAST);
    assign w_ready     = (r_state == IDLE) || w_last_stop;
    assign w_accept    = bus.tx_byte_valid && w_ready;

    // NOTE: every signal is given a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold its old value.
    always_comb begin
        w_state_next    = r_state;
        w_clk_cnt_next  = r_clk_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_shift_next    = r_shift;
        w_tx_bit_next   = 1'b1;

        case (r_state)
            IDLE: begin
                w_clk_cnt_next  = '0;
                w_bit_idx_next  = '0;
                w_stop_cnt_next = '0;
                if (w_accept) begin
                    w_state_next = START;
                    w_shift_next = bus.tx_byte_data;
                end
            end

            START: begin
                w_tx_bit_next = 1'b0;
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                w_tx_bit_next = r_shift[0];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = r_shift >> 1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_stop_cnt_next = '0;
                        w_state_next    = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (r_stop_cnt == STOP_LAST) begin
                        w_stop_cnt_next = '0;
                        if (w_accept) begin
                            w_state_next = START;
                            w_shift_next = bus.tx_byte_data;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + STOP_W'(1);
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // tx_bit and tx_active trail the state register by one clock, so the line
    // starts one cycle after the accepting edge and every bit keeps its full period.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= '0;
            r_shift     <= '0;
            r_tx_bit    <= 1'b1;
            r_tx_active <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_stop_cnt  <= w_stop_cnt_next;
            r_shift     <= w_shift_next;
            r_tx_bit    <= w_tx_bit_next;
            r_tx_active <= (r_state != IDLE);
        end
    end

    assign bus.tx_ready  = w_ready;
    assign bus.tx_bit    = r_tx_bit;
    assign bus.tx_active = r_tx_active;
    assign bus.tx_done   = w_last_stop;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line decoder model pops expected words from a scoreboard,
// plus per-scenario timing checks on an 8N1 and a 7N2 instance (10 clocks per bit).
module tb_uart_tx;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.PACK_SIZE(8)) if0 ();
    uart_tx_if #(.PACK_SIZE(7)) if1 ();

    uart_tx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .STOP_BITS(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    uart_tx #(.CLK_PER_BIT(CPB), .PACK_SIZE(7), .STOP_BITS(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb [$];
    int         frames_seen = 0;

    logic c_line [240];
    logic c_done [240];
    logic c_act  [240];
    logic c_rdy  [240];

    // Line decoder for dut0: samples mid-bit, aborts silently when a frame is cut by reset.
    bit         m_busy = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] m_data = '0;
    logic [7:0] m_exp;

    initial begin : rx_model
        forever begin
            @(negedge clk);
            if (m_busy && if0.tx_active !== 1'b1) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (if0.tx_bit === 1'b0) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt++;
            end
            if (m_busy) begin
                if (m_cnt == 5) begin
                    checks++;
                    if (if0.tx_bit !== 1'b0) begin
                        failures++;
                        $display("FAIL rx_start_bit got=%b expected=0", if0.tx_bit);
                    end
                end else if (m_cnt >= 15 && m_cnt <= 85 && (m_cnt - 15) % 10 == 0) begin
                    m_data[3'((m_cnt - 15) / 10)] = if0.tx_bit;
                end else if (m_cnt == 95) begin
                    checks++;
                    if (if0.tx_bit !== 1'b1) begin
                        failures++;
                        $display("FAIL rx_stop_bit got=%b expected=1", if0.tx_bit);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL rx_word unexpected frame got=%h expected=none", m_data);
                    end else begin
                        m_exp = sb.pop_front();
                        if (m_data !== m_exp) begin
                            failures++;
                            $display("FAIL rx_word got=%h expected=%h", m_data, m_exp);
                        end
                    end
                    frames_seen++;
                    m_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; holds valid until accepted and returns on the negedge after the accepting edge.
    task automatic send0(input logic [7:0] d);
        bit ok = 1'b0;
        if0.tx_byte_valid = 1'b1;
        if0.tx_byte_data  = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (if0.tx_ready === 1'b1) begin
                sb.push_back(d);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_accept word=%h got=no_ready expected=ready", d);
        end
    endtask

    task automatic wait_idle0();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (if0.tx_active === 1'b0 && if0.tx_ready === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_idle got=busy expected=idle");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        if0.tx_byte_valid = 1'b0;
        if0.tx_byte_data  = '0;
        if1.tx_byte_valid = 1'b0;
        if1.tx_byte_data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if0.tx_bit !== 1'b1) begin
            failures++; $display("FAIL reset_tx_bit got=%b expected=1", if0.tx_bit);
        end
        checks++;
        if (if0.tx_ready !== 1'b1) begin
            failures++; $display("FAIL reset_tx_ready got=%b expected=1", if0.tx_ready);
        end
        checks++;
        if (if0.tx_active !== 1'b0) begin
            failures++; $display("FAIL reset_tx_active got=%b expected=0", if0.tx_active);
        end
        checks++;
        if (if0.tx_done !== 1'b0) begin
            failures++; $display("FAIL reset_tx_done got=%b expected=0", if0.tx_done);
        end
        checks++;
        if (if1.tx_bit !== 1'b1 || if1.tx_ready !== 1'b1) begin
            failures++; $display("FAIL reset_dut1 got=bit%b_rdy%b expected=bit1_rdy1", if1.tx_bit, if1.tx_ready);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] d = 8'hA5;
        logic [9:0] seq;
        int nd = 0;
        int first_done = -1;
        bit ok;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = d[i];
        seq[9] = 1'b1;
        @(negedge clk);
        if0.tx_byte_valid = 1'b1;
        if0.tx_byte_data  = d;
        sb.push_back(d);
        @(negedge clk);
        if0.tx_byte_valid = 1'b0;
        if0.tx_byte_data  = 8'h00;
        for (int i = 0; i < 120; i++) begin
            if (i > 0) @(negedge clk);
            c_line[i] = if0.tx_bit;
            c_done[i] = if0.tx_done;
            c_act[i]  = if0.tx_active;
            c_rdy[i]  = if0.tx_ready;
            if (if0.tx_done === 1'b1) begin
                nd++;
                if (first_done < 0) first_done = i;
            end
        end
        checks++;
        if (c_line[0] !== 1'b1) begin
            failures++; $display("FAIL single_latency line_at_accept got=%b expected=1", c_line[0]);
        end
        for (int p = 0; p < 10; p++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) if (c_line[1 + CPB*p + k] !== seq[p]) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL single_period %0d got=%b expected=%b", p, c_line[1 + CPB*p + 5], seq[p]);
            end
        end
        checks++;
        if (nd != 1 || first_done != 99) begin
            failures++; $display("FAIL single_done count=%0d at=%0d expected count=1 at=99", nd, first_done);
        end
        checks++;
        if (c_rdy[98] !== 1'b0 || c_rdy[99] !== 1'b1 || c_rdy[101] !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b%b%b expected=011", c_rdy[98], c_rdy[99], c_rdy[101]);
        end
        checks++;
        if (c_act[0] !== 1'b0 || c_act[1] !== 1'b1 || c_act[100] !== 1'b1 || c_act[101] !== 1'b0) begin
            failures++;
            $display("FAIL single_active got=%b%b%b%b expected=0110", c_act[0], c_act[1], c_act[100], c_act[101]);
        end
        checks++;
        if (c_line[101] !== 1'b1 || c_line[119] !== 1'b1) begin
            failures++; $display("FAIL single_idle_after got=%b%b expected=11", c_line[101], c_line[119]);
        end
    endtask

    task automatic test_back_to_back();
        int pushed_at = -1;
        int n_act = 0;
        int nd = 0;
        int d0 = -1;
        int d1 = -1;
        @(negedge clk);
        checks++;
        if (if0.tx_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready_idle got=%b expected=1", if0.tx_ready);
        end
        if0.tx_byte_valid = 1'b1;
        if0.tx_byte_data  = 8'h00;
        sb.push_back(8'h00);
        @(negedge clk);
        if0.tx_byte_data = 8'hFF;
        for (int i = 0; i < 240; i++) begin
            if (i > 0) @(negedge clk);
            c_line[i] = if0.tx_bit;
            if (if0.tx_active === 1'b1) n_act++;
            if (if0.tx_done === 1'b1) begin
                nd++;
                if (d0 < 0) d0 = i; else d1 = i;
            end
            if (pushed_at >= 0) begin
                if0.tx_byte_valid = 1'b0;
            end else if (if0.tx_ready === 1'b1) begin
                sb.push_back(8'hFF);
                pushed_at = i;
            end
        end
        if0.tx_byte_valid = 1'b0;
        checks++;
        if (pushed_at != 99) begin
            failures++; $display("FAIL b2b_second_accept at=%0d expected=99", pushed_at);
        end
        checks++;
        if (c_line[100] !== 1'b1 || c_line[101] !== 1'b0) begin
            failures++; $display("FAIL b2b_no_gap got=%b%b expected=10", c_line[100], c_line[101]);
        end
        checks++;
        if (n_act != 200) begin
            failures++; $display("FAIL b2b_active_cycles got=%0d expected=200", n_act);
        end
        checks++;
        if (nd != 2 || d0 != 99 || d1 != 199) begin
            failures++; $display("FAIL b2b_done count=%0d at=%0d,%0d expected count=2 at=99,199", nd, d0, d1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] words [4];
        int f0 = frames_seen;
        words = '{8'h00, 8'hFE, 8'h55, 8'hFF};
        @(negedge clk);
        for (int i = 0; i < 4; i++) send0(words[i]);
        if0.tx_byte_valid = 1'b0;
        wait_idle0();
        checks++;
        if (frames_seen - f0 != 4 || sb.size() != 0) begin
            failures++;
            $display("FAIL loopback_frames got=%0d pending=%0d expected=4 pending=0", frames_seen - f0, sb.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int nd = 0;
        logic bit3;
        int f0;
        @(negedge clk);
        send0(8'h3C);
        if0.tx_byte_valid = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (if0.tx_done === 1'b1) nd++;
        end
        bit3 = if0.tx_bit;
        checks++;
        if (bit3 !== 1'b1) begin
            failures++; $display("FAIL rstmid_bit3 got=%b expected=1", bit3);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.tx_bit !== 1'b1 || if0.tx_active !== 1'b0 || if0.tx_ready !== 1'b1 || if0.tx_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got=bit%b_act%b_rdy%b_done%b expected=bit1_act0_rdy1_done0",
                     if0.tx_bit, if0.tx_active, if0.tx_ready, if0.tx_done);
        end
        rst = 1'b0;
        void'(sb.pop_front());
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (if0.tx_done === 1'b1 || if0.tx_bit !== 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            failures++; $display("FAIL rstmid_quiet events=%0d expected=0", nd);
        end
        f0 = frames_seen;
        send0(8'h81);
        if0.tx_byte_valid = 1'b0;
        wait_idle0();
        checks++;
        if (frames_seen - f0 != 1) begin
            failures++; $display("FAIL rstmid_resend frames=%0d expected=1", frames_seen - f0);
        end
    endtask

    task automatic test_valid_while_busy();
        int f0 = frames_seen;
        int bad = 0;
        logic rdy;
        @(negedge clk);
        send0(8'h34);
        if0.tx_byte_valid = 1'b0;
        repeat (30) @(negedge clk);
        rdy = if0.tx_ready;
        checks++;
        if (rdy !== 1'b0) begin
            failures++; $display("FAIL busy_ready got=%b expected=0", rdy);
        end
        if0.tx_byte_valid = 1'b1;
        if0.tx_byte_data  = 8'h12;
        @(negedge clk);
        if0.tx_byte_valid = 1'b0;
        wait_idle0();
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (if0.tx_bit !== 1'b1 || if0.tx_active !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL busy_line_idle busy_cycles=%0d expected=0", bad);
        end
        checks++;
        if (frames_seen - f0 != 1) begin
            failures++; $display("FAIL busy_frames got=%0d expected=1", frames_seen - f0);
        end
    endtask

    task automatic test_stop2_pack7();
        logic [6:0] d = 7'h41;
        logic [9:0] seq;
        int nd = 0;
        int first_done = -1;
        bit ok;
        seq[0] = 1'b0;
        for (int i = 0; i < 7; i++) seq[1+i] = d[i];
        seq[8] = 1'b1;
        seq[9] = 1'b1;
        @(negedge clk);
        checks++;
        if (if1.tx_ready !== 1'b1) begin
            failures++; $display("FAIL s2_ready_idle got=%b expected=1", if1.tx_ready);
        end
        if1.tx_byte_valid = 1'b1;
        if1.tx_byte_data  = d;
        @(negedge clk);
        if1.tx_byte_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (i > 0) @(negedge clk);
            c_line[i] = if1.tx_bit;
            c_act[i]  = if1.tx_active;
            if (if1.tx_done === 1'b1) begin
                nd++;
                if (first_done < 0) first_done = i;
            end
        end
        for (int p = 0; p < 10; p++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) if (c_line[1 + CPB*p + k] !== seq[p]) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL s2_period %0d got=%b expected=%b", p, c_line[1 + CPB*p + 5], seq[p]);
            end
        end
        checks++;
        if (nd != 1 || first_done != 99) begin
            failures++; $display("FAIL s2_done count=%0d at=%0d expected count=1 at=99", nd, first_done);
        end
        checks++;
        if (c_act[1] !== 1'b1 || c_act[100] !== 1'b1 || c_act[101] !== 1'b0 || c_line[101] !== 1'b1) begin
            failures++;
            $display("FAIL s2_frame_len got=act%b%b%b_line%b expected=act110_line1",
                     c_act[1], c_act[100], c_act[101], c_line[101]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_loopback();
        test_reset_mid_frame();
        test_valid_while_busy();
        test_stop2_pack7();
        checks++;
        if (sb.size() != 0 || m_busy) begin
            failures++; $display("FAIL final_scoreboard pending=%0d busy=%0d expected pending=0 busy=0", sb.size(), m_busy);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
